alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Reservation station and select stage for the single-cycle integer ALU.
- Accepts one renamed ALU micro-op per cycle from dispatch and tracks source readiness via CDB wakeup.
- Selects one ready entry per cycle and presents it in a registered issue slot. That slot drives the PRF read ports and the ALU's op/imm/pc/prd/rob_tag inputs.

Parameters:
- DATA_WIDTH, 32, width of immediate and PC fields
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical register index width
- RS_DEPTH, 8, number of entries (power of 2, ≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- i_flush  input  1  mispredict/exception flush; kills all entries and the issue slot
- i_disp_valid  input  1  dispatch offers a micro-op
- o_disp_ready  output  1  queue can accept a micro-op this cycle
- i_disp_prs1  input  PREG_WIDTH  source 1 physical reg
- i_disp_rs1_rdy  input  1  source 1 already available in PRF
- i_disp_prs2  input  PREG_WIDTH  source 2 physical reg
- i_disp_rs2_rdy  input  1  source 2 already available
- i_disp_use_imm  input  1  op2 is the immediate; source 2 ignored for readiness
- i_disp_imm  input  DATA_WIDTH  immediate (already shifted for LUI/AUIPC)
- i_disp_pc  input  DATA_WIDTH  instruction PC
- i_disp_alu_op  input  4  ALU opcode (0000 ADD … 1011 SLTU)
- i_disp_prd  input  PREG_WIDTH  destination physical reg
- i_disp_rob_tag  input  ROB_WIDTH  ROB tag
- i_cdb_valid  input  1  CDB broadcast valid
- i_cdb_prd  input  PREG_WIDTH  physical reg being written
- o_issue_valid  output  1  issue slot holds a micro-op
- i_issue_ready  input  1  downstream (PRF read/ALU/CDB grant) consumes the slot this cycle
- o_issue_prs1, o_issue_prs2  output  PREG_WIDTH  PRF read addresses
- o_issue_use_imm  output  1  select imm for ALU op2
- o_issue_imm, o_issue_pc  output  DATA_WIDTH  pass-through fields
- o_issue_alu_op  output  4  ALU opcode
- o_issue_prd  output  PREG_WIDTH  destination
- o_issue_rob_tag  output  ROB_WIDTH  ROB tag
- o_count  output  $clog2(RS_DEPTH)+1  number of valid entries

Behaviour:
- Reset (rst_n=0 at edge): all entry valid bits clear; o_issue_valid=0; all o_issue_* fields 0; o_count=0. o_disp_ready=0 while rst_n is low, otherwise combinational.
- o_disp_ready = rst_n && !i_flush && (o_count < RS_DEPTH). It is independent of i_disp_valid and does not count the entry freed by a same-cycle issue.
- Dispatch accept (i_disp_valid && o_disp_ready):
  - Written into the lowest-index free entry.
  - rdy1 = i_disp_rs1_rdy || (i_cdb_valid && i_cdb_prd == i_disp_prs1). rdy2 is formed the same way for prs2.
  - When i_disp_use_imm=1, rdy2 is forced to 1.
- Wakeup: every valid entry with prsN == i_cdb_prd and i_cdb_valid sets rdyN at the edge. Readiness used for select is the registered rdy bits only, so a woken entry is selectable the following cycle.
- Entry eligible = valid && rdy1 && rdy2. A dispatched entry is never eligible in its dispatch cycle.
- Slot free = !o_issue_valid || i_issue_ready.
  - If the slot is free and any entry is eligible: the lowest-index eligible entry loads the issue slot (o_issue_valid=1 next edge) and its valid bit clears at the same edge.
  - If the slot is free and no entry is eligible: o_issue_valid=0 next edge.
  - If the slot is not free: slot and all fields hold unchanged, and no entry is removed.
- No fairness guarantee beyond lowest-index priority.
- Latency: dispatch at edge N with both sources ready → o_issue_valid at edge N+1 if the slot is free.
- o_count is updated every edge as +accept −select, so simultaneous accept and select leave it unchanged. It saturates at neither end because legal handshakes prevent overflow and underflow.
- Flush (i_flush=1 at edge): all entries invalid, o_issue_valid=0, o_count=0. Dispatch and select in that cycle are discarded, and a CDB wakeup has no lasting effect. Flush has priority over everything except reset.
- Reset asserted mid-operation behaves as flush, plus all output fields are zeroed.

Test Plan:
- Reset, then dispatch ADD prs1=5 rdy, prs2=6 rdy, prd=20, rob=3 → next cycle o_issue_valid=1, prs1=5, prs2=6, alu_op=0000, prd=20, rob_tag=3; o_count returns to 0 once i_issue_ready=1.
- Dispatch SUB prs1=9 not ready; CDB prd=9 two cycles later → issue valid exactly one cycle after the CDB edge, never before.
- Same-cycle bypass: dispatch prs1=12 rdy=0 while i_cdb_valid=1, i_cdb_prd=12 (use_imm=1) → issues the next cycle.
- Fill 8 ready entries with i_issue_ready=0 → o_disp_ready=0 at count 8 and a 9th offer is not accepted. The issue slot holds entry 0 stable; raising i_issue_ready drains entries in index order 0..7, one per cycle.
- With 3 entries valid and the slot occupied, assert i_flush with a simultaneous dispatch → next cycle o_count=0, o_issue_valid=0, and the dispatched op never issues.
- LUI with use_imm=1, imm=0x12345000, prs2=0 rdy=0 → issues immediately with o_issue_use_imm=1 and o_issue_imm=0x12345000.

Source files
------------

// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB wakeup and issue-slot signals of the ALU issue queue.
interface alu_issue_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int RS_DEPTH   = 8
);
  logic                          i_disp_valid;
  logic                          o_disp_ready;
  logic [PREG_WIDTH-1:0]         i_disp_prs1;
  logic                          i_disp_rs1_rdy;
  logic [PREG_WIDTH-1:0]         i_disp_prs2;
  logic                          i_disp_rs2_rdy;
  logic                          i_disp_use_imm;
  logic [DATA_WIDTH-1:0]         i_disp_imm;
  logic [DATA_WIDTH-1:0]         i_disp_pc;
  logic [3:0]                    i_disp_alu_op;
  logic [PREG_WIDTH-1:0]         i_disp_prd;
  logic [ROB_WIDTH-1:0]          i_disp_rob_tag;
  logic                          i_cdb_valid;
  logic [PREG_WIDTH-1:0]         i_cdb_prd;
  logic                          o_issue_valid;
  logic                          i_issue_ready;
  logic [PREG_WIDTH-1:0]         o_issue_prs1;
  logic [PREG_WIDTH-1:0]         o_issue_prs2;
  logic                          o_issue_use_imm;
  logic [DATA_WIDTH-1:0]         o_issue_imm;
  logic [DATA_WIDTH-1:0]         o_issue_pc;
  logic [3:0]                    o_issue_alu_op;
  logic [PREG_WIDTH-1:0]         o_issue_prd;
  logic [ROB_WIDTH-1:0]          o_issue_rob_tag;
  logic [$clog2(RS_DEPTH):0]     o_count;

  // Dispatch / CDB / ALU side
  modport master (
    output i_disp_valid, i_disp_prs1, i_disp_rs1_rdy, i_disp_prs2, i_disp_rs2_rdy,
           i_disp_use_imm, i_disp_imm, i_disp_pc, i_disp_alu_op, i_disp_prd,
           i_disp_rob_tag, i_cdb_valid, i_cdb_prd, i_issue_ready,
    input  o_disp_ready, o_issue_valid, o_issue_prs1, o_issue_prs2, o_issue_use_imm,
           o_issue_imm, o_issue_pc, o_issue_alu_op, o_issue_prd, o_issue_rob_tag,
           o_count
  );

  // Issue queue side
  modport slave (
    input  i_disp_valid, i_disp_prs1, i_disp_rs1_rdy, i_disp_prs2, i_disp_rs2_rdy,
           i_disp_use_imm, i_disp_imm, i_disp_pc, i_disp_alu_op, i_disp_prd,
           i_disp_rob_tag, i_cdb_valid, i_cdb_prd, i_issue_ready,
    output o_disp_ready, o_issue_valid, o_issue_prs1, o_issue_prs2, o_issue_use_imm,
           o_issue_imm, o_issue_pc, o_issue_alu_op, o_issue_prd, o_issue_rob_tag,
           o_count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Reservation station + select stage for the single-cycle integer ALU.
// Lowest-index free entry takes dispatch; lowest-index ready entry issues
// into a registered slot that holds while the downstream stalls.
module alu_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int RS_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  alu_issue_queue_if.slave   bus
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = $clog2(RS_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RS_DEPTH);

  logic [RS_DEPTH-1:0]   ent_valid;
  logic [RS_DEPTH-1:0]   ent_rdy1;
  logic [RS_DEPTH-1:0]   ent_rdy2;
  logic [RS_DEPTH-1:0]   ent_use_imm;
  logic [PREG_WIDTH-1:0] ent_prs1   [RS_DEPTH];
  logic [PREG_WIDTH-1:0] ent_prs2   [RS_DEPTH];
  logic [DATA_WIDTH-1:0] ent_imm    [RS_DEPTH];
  logic [DATA_WIDTH-1:0] ent_pc     [RS_DEPTH];
  logic [3:0]            ent_alu_op [RS_DEPTH];
  logic [PREG_WIDTH-1:0] ent_prd    [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  ent_rob    [RS_DEPTH];

  logic                  issue_valid_q;
  logic [PREG_WIDTH-1:0] issue_prs1_q;
  logic [PREG_WIDTH-1:0] issue_prs2_q;
  logic                  issue_use_imm_q;
  logic [DATA_WIDTH-1:0] issue_imm_q;
  logic [DATA_WIDTH-1:0] issue_pc_q;
  logic [3:0]            issue_alu_op_q;
  logic [PREG_WIDTH-1:0] issue_prd_q;
  logic [ROB_WIDTH-1:0]  issue_rob_q;
  logic [CW-1:0]         count_q;

  logic [RS_DEPTH-1:0]   elig;
  logic                  any_elig;
  logic [IW-1:0]         sel_idx;
  logic [IW-1:0]         free_idx;
  logic                  disp_ready;
  logic                  accept;
  logic                  slot_free;
  logic                  do_sel;
  logic                  disp_rdy1;
  logic                  disp_rdy2;

  assign disp_ready = rst_n && !i_flush && (count_q < DEPTH_C);
  assign accept     = bus.i_disp_valid && disp_ready;
  assign slot_free  = !issue_valid_q || bus.i_issue_ready;
  assign do_sel     = slot_free && any_elig;
  assign elig       = ent_valid & ent_rdy1 & ent_rdy2;

  // Same-cycle CDB bypass into the dispatched entry's ready bits
  assign disp_rdy1 = bus.i_disp_rs1_rdy ||
                     (bus.i_cdb_valid && (bus.i_cdb_prd == bus.i_disp_prs1));
  assign disp_rdy2 = bus.i_disp_use_imm || bus.i_disp_rs2_rdy ||
                     (bus.i_cdb_valid && (bus.i_cdb_prd == bus.i_disp_prs2));

  // Lowest-index priority pick of the eligible entry and the free entry
  always_comb begin
    logic found_free;
    any_elig   = 1'b0;
    sel_idx    = '0;
    found_free = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (!any_elig && elig[i]) begin
        any_elig = 1'b1;
        sel_idx  = IW'(i);
      end
      if (!found_free && !ent_valid[i]) begin
        found_free = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Entry valid/ready bookkeeping: dispatch write, select removal, CDB wakeup
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      ent_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (accept && (free_idx == IW'(i))) begin
          ent_valid[i] <= 1'b1;
          ent_rdy1[i]  <= disp_rdy1;
          ent_rdy2[i]  <= disp_rdy2;
        end else begin
          if (do_sel && (sel_idx == IW'(i))) ent_valid[i] <= 1'b0;
          if (bus.i_cdb_valid && (ent_prs1[i] == bus.i_cdb_prd)) ent_rdy1[i] <= 1'b1;
          if (bus.i_cdb_valid && (ent_prs2[i] == bus.i_cdb_prd)) ent_rdy2[i] <= 1'b1;
        end
      end
    end
  end

  // Entry payload capture; accept is already masked by reset and flush
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_use_imm[free_idx] <= bus.i_disp_use_imm;
      ent_prs1[free_idx]    <= bus.i_disp_prs1;
      ent_prs2[free_idx]    <= bus.i_disp_prs2;
      ent_imm[free_idx]     <= bus.i_disp_imm;
      ent_pc[free_idx]      <= bus.i_disp_pc;
      ent_alu_op[free_idx]  <= bus.i_disp_alu_op;
      ent_prd[free_idx]     <= bus.i_disp_prd;
      ent_rob[free_idx]     <= bus.i_disp_rob_tag;
    end
  end

  // Issue slot: load on free slot, hold while downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_valid_q   <= 1'b0;
      issue_prs1_q    <= '0;
      issue_prs2_q    <= '0;
      issue_use_imm_q <= 1'b0;
      issue_imm_q     <= '0;
      issue_pc_q      <= '0;
      issue_alu_op_q  <= '0;
      issue_prd_q     <= '0;
      issue_rob_q     <= '0;
    end else if (i_flush) begin
      issue_valid_q <= 1'b0;
    end else if (slot_free) begin
      issue_valid_q <= any_elig;
      if (any_elig) begin
        issue_prs1_q    <= ent_prs1[sel_idx];
        issue_prs2_q    <= ent_prs2[sel_idx];
        issue_use_imm_q <= ent_use_imm[sel_idx];
        issue_imm_q     <= ent_imm[sel_idx];
        issue_pc_q      <= ent_pc[sel_idx];
        issue_alu_op_q  <= ent_alu_op[sel_idx];
        issue_prd_q     <= ent_prd[sel_idx];
        issue_rob_q     <= ent_rob[sel_idx];
      end
    end
  end

  // Occupancy counter: +accept -select
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) count_q <= '0;
    else                   count_q <= count_q + CW'(accept) - CW'(do_sel);
  end

  assign bus.o_disp_ready    = disp_ready;
  assign bus.o_issue_valid   = issue_valid_q;
  assign bus.o_issue_prs1    = issue_prs1_q;
  assign bus.o_issue_prs2    = issue_prs2_q;
  assign bus.o_issue_use_imm = issue_use_imm_q;
  assign bus.o_issue_imm     = issue_imm_q;
  assign bus.o_issue_pc      = issue_pc_q;
  assign bus.o_issue_alu_op  = issue_alu_op_q;
  assign bus.o_issue_prd     = issue_prd_q;
  assign bus.o_issue_rob_tag = issue_rob_q;
  assign bus.o_count         = count_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios then random traffic,
// all compared against a per-edge behavioural model of the queue.
module tb_alu_issue_queue;
  logic clk = 1'b0;
  logic rst_n;
  logic i_flush;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DATA_WIDTH(32), .ROB_WIDTH(4), .PREG_WIDTH(7), .RS_DEPTH(8)) bus ();

  alu_issue_queue #(.DATA_WIDTH(32), .ROB_WIDTH(4), .PREG_WIDTH(7), .RS_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .bus(bus)
  );

  typedef struct packed {
    logic        v;
    logic        r1;
    logic        r2;
    logic        ui;
    logic [6:0]  p1;
    logic [6:0]  p2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [6:0]  prd;
    logic [3:0]  rob;
  } ent_t;

  ent_t m_q [8];
  ent_t m_slot = '0;
  logic m_iv = 1'b0;
  int   m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    return rst_n && !i_flush && (m_cnt < 8);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    ent_t nq [8];
    ent_t e;
    int sel = -1;
    int fr  = -1;
    logic cm1, cm2;
    for (int i = 0; i < 8; i++) nq[i] = m_q[i];
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) nq[i].v = 1'b0;
      m_iv = 1'b0;
      m_slot = '0;
    end else if (i_flush) begin
      for (int i = 0; i < 8; i++) nq[i].v = 1'b0;
      m_iv = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sel < 0 && m_q[i].v && m_q[i].r1 && m_q[i].r2) sel = i;
        if (fr < 0 && !m_q[i].v) fr = i;
        if (bus.i_cdb_valid && m_q[i].v && m_q[i].p1 == bus.i_cdb_prd) nq[i].r1 = 1'b1;
        if (bus.i_cdb_valid && m_q[i].v && m_q[i].p2 == bus.i_cdb_prd) nq[i].r2 = 1'b1;
      end
      if (!m_iv || bus.i_issue_ready) begin
        if (sel >= 0) begin
          m_slot = m_q[sel];
          nq[sel].v = 1'b0;
          m_iv = 1'b1;
        end else begin
          m_iv = 1'b0;
        end
      end
      if (bus.i_disp_valid && m_cnt < 8 && fr >= 0) begin
        cm1 = bus.i_cdb_valid && (bus.i_cdb_prd == bus.i_disp_prs1);
        cm2 = bus.i_cdb_valid && (bus.i_cdb_prd == bus.i_disp_prs2);
        e.v   = 1'b1;
        e.r1  = bus.i_disp_rs1_rdy || cm1;
        e.r2  = bus.i_disp_use_imm || bus.i_disp_rs2_rdy || cm2;
        e.ui  = bus.i_disp_use_imm;
        e.p1  = bus.i_disp_prs1;
        e.p2  = bus.i_disp_prs2;
        e.imm = bus.i_disp_imm;
        e.pc  = bus.i_disp_pc;
        e.op  = bus.i_disp_alu_op;
        e.prd = bus.i_disp_prd;
        e.rob = bus.i_disp_rob_tag;
        nq[fr] = e;
      end
    end
    m_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      m_q[i] = nq[i];
      if (nq[i].v === 1'b1) m_cnt++;
    end
  endtask

  // One clock: check ready before the edge, step model, check state after
  task automatic cycle();
    #1;
    chk("disp_ready", 64'(bus.o_disp_ready), 64'(model_ready()));
    model_step();
    @(posedge clk);
    #1;
    chk("issue_valid", 64'(bus.o_issue_valid), 64'(m_iv));
    chk("count", 64'(bus.o_count), 64'(m_cnt));
    if (m_iv) begin
      chk("issue_prs1", 64'(bus.o_issue_prs1), 64'(m_slot.p1));
      chk("issue_prs2", 64'(bus.o_issue_prs2), 64'(m_slot.p2));
      chk("issue_use_imm", 64'(bus.o_issue_use_imm), 64'(m_slot.ui));
      chk("issue_imm", 64'(bus.o_issue_imm), 64'(m_slot.imm));
      chk("issue_pc", 64'(bus.o_issue_pc), 64'(m_slot.pc));
      chk("issue_alu_op", 64'(bus.o_issue_alu_op), 64'(m_slot.op));
      chk("issue_prd", 64'(bus.o_issue_prd), 64'(m_slot.prd));
      chk("issue_rob", 64'(bus.o_issue_rob_tag), 64'(m_slot.rob));
    end
  endtask

  task automatic set_disp(input logic v, input logic [3:0] op, input logic [6:0] p1,
                          input logic r1, input logic [6:0] p2, input logic r2,
                          input logic ui, input logic [31:0] imm, input logic [6:0] prd,
                          input logic [3:0] rob);
    bus.i_disp_valid   = v;
    bus.i_disp_alu_op  = op;
    bus.i_disp_prs1    = p1;
    bus.i_disp_rs1_rdy = r1;
    bus.i_disp_prs2    = p2;
    bus.i_disp_rs2_rdy = r2;
    bus.i_disp_use_imm = ui;
    bus.i_disp_imm     = imm;
    bus.i_disp_pc      = 32'h1000 + 32'(prd) * 4;
    bus.i_disp_prd     = prd;
    bus.i_disp_rob_tag = rob;
  endtask

  logic [6:0] drain_exp [9];

  initial begin
    drain_exp = '{7'd34, 7'd33, 7'd35, 7'd36, 7'd37, 7'd38, 7'd39, 7'd40, 7'd0};
    rst_n = 1'b0;
    i_flush = 1'b0;
    set_disp(1'b0, 4'd0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 32'd0, 7'd0, 4'd0);
    bus.i_cdb_valid = 1'b0;
    bus.i_cdb_prd = '0;
    bus.i_issue_ready = 1'b1;

    // Reset
    cycle();
    cycle();
    chk("rst_ready_low", 64'(bus.o_disp_ready), 64'd0);
    chk("rst_valid", 64'(bus.o_issue_valid), 64'd0);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_prd", 64'(bus.o_issue_prd), 64'd0);
    chk("rst_imm", 64'(bus.o_issue_imm), 64'd0);
    rst_n = 1'b1;

    // ADD, both sources ready: issues one edge after dispatch
    set_disp(1'b1, 4'd0, 7'd5, 1'b1, 7'd6, 1'b1, 1'b0, 32'd0, 7'd20, 4'd3);
    cycle();
    chk("add_not_same_cycle", 64'(bus.o_issue_valid), 64'd0);
    bus.i_disp_valid = 1'b0;
    cycle();
    chk("add_valid", 64'(bus.o_issue_valid), 64'd1);
    chk("add_prs1", 64'(bus.o_issue_prs1), 64'd5);
    chk("add_prs2", 64'(bus.o_issue_prs2), 64'd6);
    chk("add_op", 64'(bus.o_issue_alu_op), 64'd0);
    chk("add_prd", 64'(bus.o_issue_prd), 64'd20);
    chk("add_rob", 64'(bus.o_issue_rob_tag), 64'd3);
    cycle();
    chk("add_count0", 64'(bus.o_count), 64'd0);

    // SUB waiting on prs1=9, woken two cycles after dispatch
    set_disp(1'b1, 4'd1, 7'd9, 1'b0, 7'd3, 1'b1, 1'b0, 32'd0, 7'd21, 4'd4);
    cycle();
    bus.i_disp_valid = 1'b0;
    cycle();
    chk("sub_wait1", 64'(bus.o_issue_valid), 64'd0);
    bus.i_cdb_valid = 1'b1;
    bus.i_cdb_prd = 7'd9;
    cycle();
    chk("sub_wake_edge", 64'(bus.o_issue_valid), 64'd0);
    bus.i_cdb_valid = 1'b0;
    cycle();
    chk("sub_valid", 64'(bus.o_issue_valid), 64'd1);
    chk("sub_op", 64'(bus.o_issue_alu_op), 64'd1);
    chk("sub_prd", 64'(bus.o_issue_prd), 64'd21);
    cycle();

    // Same-cycle CDB bypass at dispatch
    set_disp(1'b1, 4'd2, 7'd12, 1'b0, 7'd77, 1'b0, 1'b1, 32'h10, 7'd22, 4'd5);
    bus.i_cdb_valid = 1'b1;
    bus.i_cdb_prd = 7'd12;
    cycle();
    chk("byp_not_same_cycle", 64'(bus.o_issue_valid), 64'd0);
    bus.i_disp_valid = 1'b0;
    bus.i_cdb_valid = 1'b0;
    cycle();
    chk("byp_valid", 64'(bus.o_issue_valid), 64'd1);
    chk("byp_prs1", 64'(bus.o_issue_prs1), 64'd12);
    cycle();

    // LUI with immediate, prs2 not ready but ignored
    set_disp(1'b1, 4'd0, 7'd0, 1'b1, 7'd0, 1'b0, 1'b1, 32'h12345000, 7'd30, 4'd6);
    cycle();
    bus.i_disp_valid = 1'b0;
    cycle();
    chk("lui_valid", 64'(bus.o_issue_valid), 64'd1);
    chk("lui_use_imm", 64'(bus.o_issue_use_imm), 64'd1);
    chk("lui_imm", 64'(bus.o_issue_imm), 64'h12345000);
    cycle();
    cycle();

    // Fill with the slot stalled, then drain in index order
    bus.i_issue_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_disp(1'b1, 4'd3, 7'd1, 1'b1, 7'd2, 1'b1, 1'b0, 32'(k), 7'(32 + k), 4'(k));
      cycle();
    end
    #1;
    chk("full_ready", 64'(bus.o_disp_ready), 64'd0);
    chk("full_count", 64'(bus.o_count), 64'd8);
    chk("full_slot_prd", 64'(bus.o_issue_prd), 64'd32);
    bus.i_disp_valid = 1'b0;
    bus.i_issue_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("drain_valid", 64'(bus.o_issue_valid), (k < 8) ? 64'd1 : 64'd0);
      if (k < 8) chk("drain_prd", 64'(bus.o_issue_prd), 64'(drain_exp[k]));
    end

    // Flush with 3 entries queued, slot occupied and a same-cycle dispatch
    bus.i_issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(1'b1, 4'd4, 7'd1, 1'b1, 7'd2, 1'b1, 1'b0, 32'd0, 7'(50 + k), 4'(k));
      cycle();
    end
    chk("pre_flush_count", 64'(bus.o_count), 64'd3);
    chk("pre_flush_valid", 64'(bus.o_issue_valid), 64'd1);
    i_flush = 1'b1;
    set_disp(1'b1, 4'd5, 7'd1, 1'b1, 7'd2, 1'b1, 1'b0, 32'd0, 7'd99, 4'd9);
    cycle();
    chk("flush_count", 64'(bus.o_count), 64'd0);
    chk("flush_valid", 64'(bus.o_issue_valid), 64'd0);
    i_flush = 1'b0;
    bus.i_disp_valid = 1'b0;
    bus.i_issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("post_flush_idle", 64'(bus.o_issue_valid), 64'd0);
    end

    // Random traffic with rare flushes and one mid-run reset
    for (int it = 0; it < 600; it++) begin
      rst_n = (it == 300) ? 1'b0 : 1'b1;
      i_flush = ($urandom % 40) == 0;
      set_disp(($urandom % 4) != 0, 4'($urandom % 12), 7'($urandom % 8), 1'($urandom % 2),
               7'($urandom % 8), 1'($urandom % 2), ($urandom % 4) == 0, $urandom,
               7'($urandom), 4'($urandom));
      bus.i_cdb_valid = 1'($urandom % 2);
      bus.i_cdb_prd = 7'($urandom % 8);
      bus.i_issue_ready = ($urandom % 3) != 0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
